reg_scoreboard_ctrl: RTL and testbench

- Issue-side hazard controller for the 32-entry register file.
- Tracks in-flight register writes with one busy bit per register.
- Stalls issue on RAW or WAW hazards and clears busy bits on writeback.
- Sits between decode and the register-file read stage. Also provides pipeline flush, a drain handshake and a stall counter.

---
 rtl/reg_scoreboard_if.sv | 29 ++
 rtl/reg_scoreboard_ctrl.sv | 58 +++++
 tb/tb_reg_scoreboard_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback/drain signals between the pipeline and the register scoreboard
interface reg_scoreboard_if #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   issue_valid;
  logic [ADDR_W-1:0]      issue_rs1;
  logic [ADDR_W-1:0]      issue_rs2;
  logic [ADDR_W-1:0]      issue_rd;
  logic                   issue_rd_wr;
  logic                   issue_ready;
  logic                   issue_fire;
  logic                   wb_valid;
  logic [ADDR_W-1:0]      wb_rd;
  logic                   flush;
  logic                   drain_req;
  logic                   drain_done;
  logic [NUM_REGS-1:0]    busy_vec;
  logic [STALL_CNT_W-1:0] stall_cnt;
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_wr, wb_valid, wb_rd, flush, drain_req,
    input  issue_ready, issue_fire, drain_done, busy_vec, stall_cnt
  );
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_wr, wb_valid, wb_rd, flush, drain_req,
    output issue_ready, issue_fire, drain_done, busy_vec, stall_cnt
  );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// reg_scoreboard_ctrl: busy-bit scoreboard that stalls issue on RAW/WAW hazards, with flush, drain handshake and stall counter.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback unblock issue immediately.
module reg_scoreboard_ctrl #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_scoreboard_if.slave sb
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;
  state_t state, state_nx;
  logic [NUM_REGS-1:0]    busy, busy_nx, eff, set_m, clr_m;
  logic [STALL_CNT_W-1:0] stall;
  logic                   raw, waw, ready, fire, done_q;
  assign clr_m = NUM_REGS'(sb.wb_valid && sb.wb_rd != '0) << sb.wb_rd;
`ifdef SCOREBOARD_WB_BYPASS_EN
  assign eff = busy & ~clr_m;
`else
  assign eff = busy;
`endif
  assign raw   = eff[sb.issue_rs1] | eff[sb.issue_rs2];
  assign waw   = sb.issue_rd_wr & eff[sb.issue_rd];
  assign ready = rst_n & (state == RUN) & ~sb.drain_req & ~raw & ~waw & ~sb.flush;
  assign fire  = sb.issue_valid & ready;
  assign set_m = NUM_REGS'(fire && sb.issue_rd_wr && sb.issue_rd != '0) << sb.issue_rd;
  // set is applied after clear so a same-register collision leaves the bit busy
  assign busy_nx = sb.flush ? '0 : (busy & ~clr_m) | set_m;
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     state_nx = sb.drain_req ? DRAIN : RUN;
      DRAIN:   state_nx = (busy_nx == '0) ? DONE : DRAIN;
      DONE:    state_nx = HOLD;
      HOLD:    state_nx = sb.drain_req ? HOLD : RUN;
      default: state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      busy   <= '0;
      stall  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy   <= busy_nx;
      done_q <= (state_nx == DONE);
      if (sb.issue_valid && !ready && !(&stall)) stall <= stall + STALL_CNT_W'(1);
    end
  end
  assign sb.issue_ready = ready;
  assign sb.issue_fire  = fire;
  assign sb.busy_vec    = busy;
  assign sb.stall_cnt   = stall;
  assign sb.drain_done  = done_q;
endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// tb_reg_scoreboard_ctrl: directed and random stimulus checked against a behavioural scoreboard model
module tb_reg_scoreboard_ctrl;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  reg_scoreboard_if sb();
  reg_scoreboard_ctrl dut (.clk(clk), .rst_n(rst_n), .sb(sb));
  int checks = 0;
  int errors = 0;
  bit v, wr, wv, fl, dr;
  logic [4:0] rs1, rs2, rd, wrd;
  bit [31:0] m_busy;
  int m_stall;
  bit m_drain, m_done, m_hold;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(bit iv, int a, int b, int d, bit w, bit bv, int br, bit f, bit q);
    v = iv; rs1 = 5'(a); rs2 = 5'(b); rd = 5'(d); wr = w; wv = bv; wrd = 5'(br); fl = f; dr = q;
    sb.issue_valid = v; sb.issue_rs1 = rs1; sb.issue_rs2 = rs2; sb.issue_rd = rd; sb.issue_rd_wr = wr;
    sb.wb_valid = wv; sb.wb_rd = wrd; sb.flush = fl; sb.drain_req = dr;
  endtask
  function automatic bit m_ready();
    bit [31:0] e = m_busy;
    if (BYP && wv && wrd != 0) e[wrd] = 1'b0;
    return rst_n && !m_drain && !m_done && !m_hold && !dr && !fl && !e[rs1] && !e[rs2] && !(wr && e[rd]);
  endfunction
  task automatic m_reset();
    m_busy = 0; m_stall = 0; m_drain = 0; m_done = 0; m_hold = 0;
  endtask
  task automatic step(bit chk);
    bit r;
    bit [31:0] nb;
    #1;
    r = m_ready();
    if (chk) begin
      check("issue_ready", sb.issue_ready, r);
      check("issue_fire", sb.issue_fire, v & r);
    end
    @(posedge clk);
    nb = m_busy;
    if (wv && wrd != 0) nb[wrd] = 1'b0;
    if (v && r && wr && rd != 0) nb[rd] = 1'b1;
    if (fl) nb = 0;
    if (v && !r && m_stall < 65535) m_stall++;
    if (m_drain) begin
      if (nb == 0) begin m_drain = 0; m_done = 1; end
    end else if (m_done) begin
      m_done = 0; m_hold = 1;
    end else if (m_hold) begin
      if (!dr) m_hold = 0;
    end else if (dr) m_drain = 1;
    m_busy = nb;
    #1;
    if (chk) begin
      check("busy_vec", sb.busy_vec, m_busy);
      check("stall_cnt", sb.stall_cnt, m_stall);
      check("drain_done", sb.drain_done, m_done);
    end
  endtask
  initial begin
    m_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_ready", sb.issue_ready, 0);
    check("rst_busy", sb.busy_vec, 0);
    check("rst_stall", sb.stall_cnt, 0);
    check("rst_done", sb.drain_done, 0);
    rst_n = 1'b1;
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0); step(1);
    check("set_rd5", sb.busy_vec, 32'h20);
    drive(1, 5, 0, 6, 1, 0, 0, 0, 0); step(1);
    check("raw_stall1", sb.stall_cnt, 1);
    drive(1, 5, 0, 6, 1, 1, 5, 0, 0); step(1);
    check("wb_same_cycle", sb.busy_vec, BYP ? 32'h40 : 32'h0);
    if (!BYP) begin
      drive(1, 5, 0, 6, 1, 0, 0, 0, 0); step(1);
    end
    check("late_issue", sb.busy_vec, 32'h40);
    drive(0, 0, 0, 0, 0, 1, 6, 0, 0); step(1);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0); step(1);
    check("rd0_never_busy", sb.busy_vec, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step(1);
    drive(1, 0, 0, 10, 1, 0, 0, 0, 0); step(1);
    drive(1, 0, 0, 11, 1, 0, 0, 0, 0); step(1);
    check("busy_c00", sb.busy_vec, 32'hC00);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); step(1);
    check("flush_clear", sb.busy_vec, 0);
    drive(1, 10, 11, 0, 0, 0, 0, 0, 0); step(1);
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0); step(1);
    check("busy_8", sb.busy_vec, 32'h8);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1); step(1);
    check("drain_wait", sb.drain_done, 0);
    drive(1, 0, 0, 0, 0, 1, 3, 0, 1); step(1);
    check("drain_pulse", sb.drain_done, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1); step(1);
    check("drain_once", sb.drain_done, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step(1);
    for (int i = 0; i < 2000; i++) begin
      bit q = dr;
      if ($urandom_range(15) == 0) q = ~q;
      drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7), $urandom_range(7),
            $urandom_range(1), $urandom_range(1), $urandom_range(7), $urandom_range(31) == 0, q);
      step(1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(1);
    end
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0); step(1);
    check("sat_setup", sb.busy_vec, 32'h2);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0);
    step(1);
    check("stall_sat", sb.stall_cnt, 32'hFFFF);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    check("arst_busy", sb.busy_vec, 0);
    check("arst_stall", sb.stall_cnt, 0);
    check("arst_ready", sb.issue_ready, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
